// File: rtl/trig_angle_reducer_pkg.sv
// Shared constants and state type for the trig angle reduction path.
// Degree constants are 10 bits wide so that a sum of up to 359+90 fits.
package trig_angle_reducer_pkg;

  localparam logic [9:0] DEG_FULL    = 10'd360;
  localparam logic [9:0] DEG_HALF    = 10'd180;
  localparam logic [9:0] DEG_3Q      = 10'd270;
  localparam logic [9:0] DEG_QUARTER = 10'd90;

  localparam int unsigned AR_SHIFT_MAX = 22;

  typedef enum logic [1:0] {
    AR_IDLE,
    AR_REDUCE,
    AR_FOLD,
    AR_EMIT
  } ar_state_e;

endpackage

// File: rtl/trig_quadrant_fold.sv
// Combinational fold of a 0..359 angle to a quadrant and a 0..90 table index.
// When func is set, the angle is shifted by +90 first to turn a sine lookup into a cosine lookup.
module trig_quadrant_fold
  import trig_angle_reducer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [9:0]            a,
  input  logic                  func,
  output logic [1:0]            q,
  output logic [DATA_WIDTH-1:0] angle_out
);

  logic [9:0] s;
  logic [9:0] base;
  logic [9:0] o;
  logic [9:0] folded;

  always_comb begin
    s = a;
    if (func) begin
      s = s + DEG_QUARTER;
    end
    if (s >= DEG_FULL) begin
      s = s - DEG_FULL;
    end

    // Quadrant by threshold compare instead of a divide by 90.
    if (s >= DEG_3Q) begin
      q    = 2'd3;
      base = DEG_3Q;
    end else if (s >= DEG_HALF) begin
      q    = 2'd2;
      base = DEG_HALF;
    end else if (s >= DEG_QUARTER) begin
      q    = 2'd1;
      base = DEG_QUARTER;
    end else begin
      q    = 2'd0;
      base = '0;
    end

    o         = s - base;
    folded    = q[0] ? (DEG_QUARTER - o) : o;
    angle_out = DATA_WIDTH'(folded);
  end

endmodule

// File: rtl/trig_angle_reducer.sv
// Reduces a signed degree angle modulo 360 with a shift-subtract sweep, then folds it
// to a quadrant plus 0..90 index for sine_LUT. One angle in flight, fixed latency.
module trig_angle_reducer
  import trig_angle_reducer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SHIFT_MAX  = AR_SHIFT_MAX
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] angle_in,
  input  logic                  func_sel,
  output logic                  en_sine,
  output logic [1:0]            quadrant,
  output logic [DATA_WIDTH-1:0] angle_out
);

  localparam int unsigned KW = $clog2(SHIFT_MAX + 1);
  localparam logic [DATA_WIDTH:0] FULL_W = (DATA_WIDTH + 1)'(DEG_FULL);

  ar_state_e state_q, state_d;

  logic [DATA_WIDTH:0]   mag_q, mag_d;
  logic [KW-1:0]         k_q, k_d;
  logic                  neg_q, neg_d;
  logic                  func_q, func_d;
  logic                  en_sine_q, en_sine_d;
  logic [1:0]            quadrant_q, quadrant_d;
  logic [DATA_WIDTH-1:0] angle_out_q, angle_out_d;

  logic                  accept;
  logic                  last_k;
  logic [DATA_WIDTH:0]   sweep;
  logic [DATA_WIDTH:0]   ext;
  logic [9:0]            fold_r;
  logic [9:0]            fold_a;
  logic [1:0]            fold_q;
  logic [DATA_WIDTH-1:0] fold_out;

  assign in_ready  = (state_q == AR_IDLE);
  assign accept    = in_valid && in_ready;
  assign last_k    = (k_q == '0);
  assign sweep     = FULL_W << k_q;
  assign ext       = {angle_in[DATA_WIDTH-1], angle_in};
  assign en_sine   = en_sine_q;
  assign quadrant  = quadrant_q;
  assign angle_out = angle_out_q;

  // After the sweep mag_q < 360, so its low 9 bits are the full residue.
  assign fold_r = {1'b0, mag_q[8:0]};
  assign fold_a = (neg_q && (fold_r != '0)) ? (DEG_FULL - fold_r) : fold_r;

  trig_quadrant_fold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fold (
    .a        (fold_a),
    .func     (func_q),
    .q        (fold_q),
    .angle_out(fold_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= AR_IDLE;
      mag_q       <= '0;
      k_q         <= '0;
      neg_q       <= 1'b0;
      func_q      <= 1'b0;
      en_sine_q   <= 1'b0;
      quadrant_q  <= '0;
      angle_out_q <= '0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      k_q         <= k_d;
      neg_q       <= neg_d;
      func_q      <= func_d;
      en_sine_q   <= en_sine_d;
      quadrant_q  <= quadrant_d;
      angle_out_q <= angle_out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      AR_IDLE:   if (accept) state_d = AR_REDUCE;
      AR_REDUCE: if (last_k) state_d = AR_FOLD;
      AR_FOLD:   state_d = AR_EMIT;
      AR_EMIT:   state_d = AR_IDLE;
      default:   state_d = AR_IDLE;
    endcase
  end

  always_comb begin
    mag_d       = mag_q;
    k_d         = k_q;
    neg_d       = neg_q;
    func_d      = func_q;
    en_sine_d   = 1'b0;
    quadrant_d  = quadrant_q;
    angle_out_d = angle_out_q;
    case (state_q)
      AR_IDLE: begin
        if (accept) begin
          // One extra bit keeps |-2^(W-1)| representable.
          mag_d  = angle_in[DATA_WIDTH-1] ? (~ext + 1'b1) : ext;
          neg_d  = angle_in[DATA_WIDTH-1];
          func_d = func_sel;
          k_d    = KW'(SHIFT_MAX);
        end
      end
      AR_REDUCE: begin
        if (mag_q >= sweep) begin
          mag_d = mag_q - sweep;
        end
        if (!last_k) begin
          k_d = k_q - 1'b1;
        end
      end
      AR_FOLD: begin
        quadrant_d  = fold_q;
        angle_out_d = fold_out;
        en_sine_d   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trig_angle_reducer.sv
// Directed bench for trig_angle_reducer: hand-computed quadrant/index results,
// latency and pulse width, back-to-back offer spacing and mid-operation reset.
module tb_trig_angle_reducer;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] angle_in;
  logic        func_sel;
  logic        en_sine;
  logic [1:0]  quadrant;
  logic [31:0] angle_out;

  int total = 0;
  int bad   = 0;

  trig_angle_reducer #(
    .DATA_WIDTH(32),
    .SHIFT_MAX (22)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .angle_in (angle_in),
    .func_sel (func_sel),
    .en_sine  (en_sine),
    .quadrant (quadrant),
    .angle_out(angle_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at #1 after a rising edge; the next edge is the accept edge.
  task automatic run_angle(input string tag, input logic [31:0] ang, input logic fs,
                           input logic [1:0] eq, input logic [31:0] eo);
    int cyc;
    cyc = 0;
    check({tag, "_ready"}, {31'b0, in_ready}, 32'd1);
    angle_in = ang;
    func_sel = fs;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 40 && cyc == 0; i++) begin
      @(posedge clk); #1;
      if (en_sine) cyc = i;
    end
    check({tag, "_latency"}, cyc, 32'd24);
    check({tag, "_quadrant"}, {30'b0, quadrant}, {30'b0, eq});
    check({tag, "_angle_out"}, angle_out, eo);
    @(posedge clk); #1;
    check({tag, "_en_width"}, {31'b0, en_sine}, 32'd0);
    check({tag, "_ready_after"}, {31'b0, in_ready}, 32'd1);
  endtask

  int acc_c[$];
  int pls_c[$];
  logic [31:0] pls_o[$];
  logic [1:0]  pls_q[$];
  int exp_acc[3] = '{0, 26, 52};
  int exp_pls[3] = '{25, 51, 77};
  int seen;

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    angle_in = '0;
    func_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_en_sine", {31'b0, en_sine}, 32'd0);
    check("rst_quadrant", {30'b0, quadrant}, 32'd0);
    check("rst_angle_out", angle_out, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_angle("a0_sin",    32'd0,           1'b0, 2'd0, 32'd0);
    run_angle("a450_sin",  32'd450,         1'b0, 2'd1, 32'd90);
    run_angle("a120_sin",  32'd120,         1'b0, 2'd1, 32'd60);
    run_angle("m30_sin",   -32'sd30,        1'b0, 2'd3, 32'd30);
    run_angle("a200_cos",  32'd200,         1'b0 | 1'b1, 2'd3, 32'd70);
    run_angle("min_sin",   32'h8000_0000,   1'b0, 2'd2, 32'd52);
    run_angle("a359_cos",  32'd359,         1'b1, 2'd0, 32'd89);

    // in_valid held high, a new angle (= cycle index) offered every cycle.
    for (int c = 0; c < 78; c++) begin
      if (en_sine) begin
        pls_c.push_back(c);
        pls_o.push_back(angle_out);
        pls_q.push_back(quadrant);
      end
      angle_in = 32'(c);
      func_sel = 1'b0;
      in_valid = 1'b1;
      if (in_ready) acc_c.push_back(c);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("b2b_accept_count", acc_c.size(), 32'd3);
    check("b2b_pulse_count", pls_c.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("b2b_accept_cycle", (acc_c.size() > i) ? acc_c[i] : -1, exp_acc[i]);
      check("b2b_pulse_cycle", (pls_c.size() > i) ? pls_c[i] : -1, exp_pls[i]);
      check("b2b_pulse_angle", (pls_o.size() > i) ? pls_o[i] : 32'hFFFF_FFFF, 32'(exp_acc[i]));
      check("b2b_pulse_quadrant", (pls_q.size() > i) ? {30'b0, pls_q[i]} : 32'hFFFF_FFFF, 32'd0);
    end
    @(posedge clk); #1;

    // Reset 10 cycles into REDUCE for angle 200.
    angle_in = 32'd200;
    func_sel = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mid_busy_ready", {31'b0, in_ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en_sine", {31'b0, en_sine}, 32'd0);
    check("mid_rst_quadrant", {30'b0, quadrant}, 32'd0);
    check("mid_rst_angle_out", angle_out, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (en_sine) seen++;
    end
    check("mid_rst_no_pulse", seen, 32'd0);
    check("mid_rst_angle_hold", angle_out, 32'd0);
    run_angle("a90_after_rst", 32'd90, 1'b0, 2'd1, 32'd90);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
